// File: rtl/reg_cpl_gen_if.sv
// TLP transmit stream: one 64-bit beat per valid/ready handshake,
// framed by start- and end-of-packet markers.
interface reg_cpl_gen_if;
  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;

  modport master (
    output data, valid, sop, eop,
    input  ready
  );

  modport slave (
    input  data, valid, sop, eop,
    output ready
  );
endinterface

// File: rtl/reg_cpl_gen.sv
// Register action executor: writes go straight to the register bus,
// reads are turned into a 3-beat completion-with-data TLP.
package tlp_xcvr_pkg;
  typedef logic [3:0] ExtChan;

  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1
  } ActKind;

  typedef struct packed {
    ActKind      kind;
    ExtChan      chan;
    logic [63:0] data;
    logic [15:0] reqID;
    logic [7:0]  tag;
  } Action;
endpackage

module reg_cpl_gen
  import tlp_xcvr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic          pcieClk_in,
  input  logic          pcieRst_in,
  input  logic [15:0]   cpID_in,
  input  Action         actData_in,
  input  logic          actValid_in,
  output ExtChan        regChan_out,
  output logic [63:0]   regWrData_out,
  output logic          regWrValid_out,
  output logic          regRdReq_out,
  input  logic [63:0]   regRdData_in,
  input  logic          regRdValid_in,
  reg_cpl_gen_if.master tx,
  output logic          overflow_out,
  output logic          timeout_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDWAIT,
    S_HDR0,
    S_HDR1,
    S_DATA
  } state_t;

  state_t      state;
  Action       mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  cnt;
  ExtChan      rd_chan;
  logic [15:0] rd_req_id;
  logic [7:0]  rd_tag;
  logic [63:0] rd_data;

  logic  empty;
  logic  full;
  logic  pop;
  logic  push;
  Action head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == S_IDLE) && !empty;
  assign push  = actValid_in && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pcieClk_in) begin
    if (push && !pcieRst_in)
      mem[wr_ptr[AW-1:0]] <= actData_in;
  end

  // DW0: CplD, TC/attr 0, 2 DW; DW1: completer, status SC, 8 bytes
  function automatic logic [63:0] hdr0(input logic [15:0] cpid);
    return {cpid, 3'b000, 1'b0, 12'd8,
            3'b010, 5'b01010, 1'b0, 3'b000, 4'b0000,
            1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
  endfunction

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
      regChan_out    <= '0;
      regWrData_out  <= '0;
      regWrValid_out <= 1'b0;
      regRdReq_out   <= 1'b0;
      rd_chan        <= '0;
      rd_req_id      <= '0;
      rd_tag         <= '0;
      rd_data        <= '0;
      tx.data        <= '0;
      tx.valid       <= 1'b0;
      tx.sop         <= 1'b0;
      tx.eop         <= 1'b0;
    end else begin
      regWrValid_out <= 1'b0;
      regRdReq_out   <= 1'b0;

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (actValid_in && full && !pop)
        overflow_out <= 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            unique case (1'b1)
              (head.kind == REG_WRITE): begin
                regChan_out    <= head.chan;
                regWrData_out  <= head.data;
                regWrValid_out <= 1'b1;
              end
              (head.kind == REG_READ): begin
                regChan_out  <= head.chan;
                regRdReq_out <= 1'b1;
                rd_chan      <= head.chan;
                rd_req_id    <= head.reqID;
                rd_tag       <= head.tag;
                cnt          <= '0;
                state        <= S_RDWAIT;
              end
              default: ;
            endcase
          end
        end
        S_RDWAIT: begin
          if (regRdValid_in) begin
            rd_data  <= regRdData_in;
            tx.data  <= hdr0(cpID_in);
            tx.valid <= 1'b1;
            tx.sop   <= 1'b1;
            state    <= S_HDR0;
          end else if (cnt == 8'(RD_TIMEOUT)) begin
            rd_data     <= 64'hDEADBEEF_DEADBEEF;
            timeout_out <= 1'b1;
            tx.data     <= hdr0(cpID_in);
            tx.valid    <= 1'b1;
            tx.sop      <= 1'b1;
            state       <= S_HDR0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HDR0: begin
          if (tx.ready) begin
            tx.data <= {32'h0, rd_req_id, rd_tag, 1'b0,
                        rd_chan, 3'b000};
            tx.sop  <= 1'b0;
            state   <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (tx.ready) begin
            tx.data <= rd_data;
            tx.eop  <= 1'b1;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx.ready) begin
            tx.valid <= 1'b0;
            tx.eop   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cpl_gen.sv
// Scoreboard bench for reg_cpl_gen: directed actions, queued
// expectations, independent monitors for register bus and TX.
module tb_reg_cpl_gen;
  import tlp_xcvr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cp_id = 16'h0300;
  Action       act;
  logic        act_valid;
  ExtChan      reg_chan;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        rd_req;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        overflow;
  logic        timeout;

  always #4 clk = ~clk;

  reg_cpl_gen_if tx ();

  reg_cpl_gen #(.FIFO_DEPTH(4), .RD_TIMEOUT(255)) dut (
    .pcieClk_in     (clk),
    .pcieRst_in     (rst),
    .cpID_in        (cp_id),
    .actData_in     (act),
    .actValid_in    (act_valid),
    .regChan_out    (reg_chan),
    .regWrData_out  (wr_data),
    .regWrValid_out (wr_valid),
    .regRdReq_out   (rd_req),
    .regRdData_in   (rd_data),
    .regRdValid_in  (rd_valid),
    .tx             (tx.master),
    .overflow_out   (overflow),
    .timeout_out    (timeout)
  );

  typedef struct {
    ExtChan      chan;
    logic [63:0] data;
  } wr_exp_t;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    ExtChan      chan;
    int          lat;
    logic [63:0] data;
  } rd_t;

  wr_exp_t wr_q [$];
  beat_t   tx_q [$];
  rd_t     rd_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int n_sop    = 0;
  int n_eop    = 0;
  int ready_mode = 0;
  logic manual_ready = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] hdr0_exp();
    return {cp_id, 16'h0008, 32'h4A00_0002};
  endfunction

  function automatic logic [63:0] hdr1_exp(input logic [15:0] id,
                                           input logic [7:0] tg,
                                           input ExtChan ch);
    return {32'h0, id, tg, 1'b0, ch, 3'b000};
  endfunction

  task automatic push_cpl(input logic [15:0] id, input logic [7:0] tg,
                          input ExtChan ch, input logic [63:0] d);
    tx_q.push_back('{hdr0_exp(), 1'b1, 1'b0});
    tx_q.push_back('{hdr1_exp(id, tg, ch), 1'b0, 1'b0});
    tx_q.push_back('{d, 1'b0, 1'b1});
  endtask

  // Register write monitor
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (wr_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        check("wr_chan", 64'(reg_chan), 64'(e.chan));
        check("wr_data", wr_data, e.data);
      end
    end
  end

  // TX monitor with hold-stability checking
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [63:0] p_data  = '0;
  logic        p_sop   = 1'b0;
  logic        p_eop   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        check("hold_valid", 64'(tx.valid), 64'd1);
        check("hold_data", tx.data, p_data);
        check("hold_sopeop", {62'd0, tx.sop, tx.eop},
              {62'd0, p_sop, p_eop});
      end
      if (tx.valid && tx.ready) begin
        n_beats++;
        if (tx.sop) n_sop++;
        if (tx.eop) n_eop++;
        if (tx_q.size() == 0) begin
          fail_now("unexpected_tx_beat");
        end else begin
          beat_t b;
          b = tx_q.pop_front();
          check("tx_data", tx.data, b.data);
          check("tx_sop", 64'(tx.sop), 64'(b.sop));
          check("tx_eop", 64'(tx.eop), 64'(b.eop));
        end
      end
      p_valid = tx.valid;
      p_ready = tx.ready;
      p_data  = tx.data;
      p_sop   = tx.sop;
      p_eop   = tx.eop;
    end
  end

  // Register read responder
  initial begin
    rd_t r;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && rd_req) begin
        if (rd_q.size() == 0) begin
          fail_now("unexpected_rd_req");
        end else begin
          r = rd_q.pop_front();
          check("rd_chan", 64'(reg_chan), 64'(r.chan));
          if (r.lat > 0) begin
            repeat (r.lat) @(posedge clk);
            #1;
            rd_valid = 1'b1;
            rd_data  = r.data;
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
          end
        end
      end
    end
  end

  // TX ready driver: always-ready, 5-cycle stall per beat, or manual
  initial begin
    int sc;
    sc = 0;
    tx.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx.ready = 1'b1;
        1: begin
          if (!tx.valid) begin
            tx.ready = 1'b0;
            sc = 0;
          end else if (sc < 5) begin
            tx.ready = 1'b0;
            sc++;
          end else begin
            tx.ready = 1'b1;
            sc = 0;
          end
        end
        default: tx.ready = manual_ready;
      endcase
    end
  end

  task automatic drive(input ActKind k, input ExtChan c,
                       input logic [63:0] d, input logic [15:0] id,
                       input logic [7:0] tg);
    @(posedge clk);
    #1;
    act.kind  = k;
    act.chan  = c;
    act.data  = d;
    act.reqID = id;
    act.tag   = tg;
    act_valid = 1'b1;
  endtask

  task automatic release_act();
    @(posedge clk);
    #1;
    act_valid = 1'b0;
  endtask

  task automatic send(input ActKind k, input ExtChan c,
                      input logic [63:0] d, input logic [15:0] id,
                      input logic [7:0] tg);
    drive(k, c, d, id, tg);
    release_act();
  endtask

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while ((wr_q.size() != 0 || tx_q.size() != 0 || rd_q.size() != 0)
           && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) fail_now({name, "_drain_timeout"});
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_wr_valid"}, 64'(wr_valid), 64'd0);
    check({name, "_rd_req"}, 64'(rd_req), 64'd0);
    check({name, "_tx_valid"}, 64'(tx.valid), 64'd0);
    check({name, "_tx_sop"}, 64'(tx.sop), 64'd0);
    check({name, "_tx_eop"}, 64'(tx.eop), 64'd0);
    check({name, "_overflow"}, 64'(overflow), 64'd0);
    check({name, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    int b0, s0, e0, w;
    act       = '0;
    act_valid = 1'b0;
    rst       = 1'b1;

    // Actions during reset are ignored
    drive(REG_WRITE, 4'd1, 64'h1, 16'h0, 8'h0);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    act_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_act_ignored", 64'(wr_valid), 64'd0);

    // Single write
    wr_q.push_back('{4'd3, 64'h1122_3344_5566_7788});
    send(REG_WRITE, 4'd3, 64'h1122_3344_5566_7788, 16'h0, 8'h0);
    drain("write", 50);

    // Unknown kind is discarded; following write still executes
    wr_q.push_back('{4'd1, 64'hA5A5_5A5A_0F0F_F0F0});
    send(ActKind'(2'd2), 4'd7, 64'hFFFF, 16'h1, 8'h1);
    send(REG_WRITE, 4'd1, 64'hA5A5_5A5A_0F0F_F0F0, 16'h0, 8'h0);
    drain("unknown", 50);

    // Back-to-back writes
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back('{ExtChan'(8 + i), 64'h1000 + 64'(i)});
      drive(REG_WRITE, ExtChan'(8 + i), 64'h1000 + 64'(i), 16'h0, 8'h0);
    end
    release_act();
    drain("b2b_write", 50);

    // Read with hand-computed completion
    rd_q.push_back('{4'd5, 2, 64'hCAFE_F00D_1234_5678});
    tx_q.push_back('{64'h0300_0008_4A00_0002, 1'b1, 1'b0});
    tx_q.push_back('{64'h0000_0000_0100_2A28, 1'b0, 1'b0});
    tx_q.push_back('{64'hCAFE_F00D_1234_5678, 1'b0, 1'b1});
    send(REG_READ, 4'd5, 64'h0, 16'h0100, 8'h2A);
    drain("read", 100);

    // Read with 5-cycle stalls on every beat
    ready_mode = 1;
    b0 = n_beats;
    s0 = n_sop;
    e0 = n_eop;
    rd_q.push_back('{4'd5, 2, 64'h0123_4567_89AB_CDEF});
    push_cpl(16'h0100, 8'h2A, 4'd5, 64'h0123_4567_89AB_CDEF);
    send(REG_READ, 4'd5, 64'h0, 16'h0100, 8'h2A);
    drain("stall", 200);
    check("stall_beats", 64'(n_beats - b0), 64'd3);
    check("stall_sop", 64'(n_sop - s0), 64'd1);
    check("stall_eop", 64'(n_eop - e0), 64'd1);
    ready_mode = 0;

    // Overflow while waiting on slow read data
    rd_q.push_back('{4'd2, 20, 64'h5555_6666_7777_8888});
    push_cpl(16'h1234, 8'h07, 4'd2, 64'h5555_6666_7777_8888);
    send(REG_READ, 4'd2, 64'h0, 16'h1234, 8'h07);
    w = 0;
    while (rd_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) fail_now("ovf_rdreq_wait");
    check("ovf_before", 64'(overflow), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) wr_q.push_back('{ExtChan'(i), 64'hF000 + 64'(i)});
      drive(REG_WRITE, ExtChan'(i), 64'hF000 + 64'(i), 16'h0, 8'h0);
    end
    release_act();
    @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    drain("overflow", 200);

    // Read timeout
    rd_q.push_back('{4'd9, 0, 64'h0});
    push_cpl(16'h4321, 8'hC3, 4'd9, 64'hDEAD_BEEF_DEAD_BEEF);
    send(REG_READ, 4'd9, 64'h0, 16'h4321, 8'hC3);
    drain("timeout", 600);
    check("timeout_flag", 64'(timeout), 64'd1);

    // Reset while HDR1 is being presented
    manual_ready = 1'b0;
    ready_mode   = 2;
    repeat (2) @(negedge clk);
    rd_q.push_back('{4'd6, 2, 64'h7777_0000_7777_0000});
    tx_q.push_back('{hdr0_exp(), 1'b1, 1'b0});
    send(REG_READ, 4'd6, 64'h0, 16'hBEEF, 8'h11);
    w = 0;
    while (!(tx.valid && tx.sop) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) fail_now("rst_sop_wait");
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    @(negedge clk);
    check("hdr1_presented", {61'd0, tx.valid, tx.sop, tx.eop},
          64'b100);
    check("hdr1_data", tx.data, hdr1_exp(16'hBEEF, 8'h11, 4'd6));
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midtlp_rst");
    rst = 1'b0;
    ready_mode = 0;
    check("rst_tx_q_empty", 64'(tx_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Fresh read after reset
    rd_q.push_back('{4'd4, 1, 64'h0BAD_F00D_0000_0001});
    push_cpl(16'h00AA, 8'h55, 4'd4, 64'h0BAD_F00D_0000_0001);
    send(REG_READ, 4'd4, 64'h0, 16'h00AA, 8'h55);
    drain("post_rst_read", 100);
    check("post_rst_timeout", 64'(timeout), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
